agc_gain_control: RTL and testbench

AGC_GAIN_CONTROL -- requirements
Module: agc_gain_control

---
 rtl/agc_gain_control_pkg.sv | 16 +
 rtl/agc_abs.sv | 14 +
 rtl/agc_defs.vh | 14 +
 rtl/agc_gain_control.sv | 130 +++++++++++++
 tb/tb_agc_gain_control.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/agc_gain_control_pkg.sv
// Types shared by the AGC block, built on the common AGC definitions.
package agc_gain_control_pkg;
  `include "agc_defs.vh"

  typedef enum logic [1:0] {
    ST_ACCUM  = AGC_ST_ACCUM,
    ST_EVAL   = AGC_ST_EVAL,
    ST_UPDATE = AGC_ST_UPDATE
  } agc_state_e;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_UP   = 2'd1,
    DIR_DOWN = 2'd2
  } agc_dir_e;
endpackage

// File: rtl/agc_abs.sv
// Saturating magnitude of a 12-bit two's-complement sample (-2048 maps to 2047).
module agc_abs (
  input  logic signed [11:0] data_i,
  output logic        [11:0] mag_o
);
  always_comb begin
    mag_o = $unsigned(data_i);
    if (data_i == -12'sd2048) begin
      mag_o = 12'd2047;
    end else if (data_i[11]) begin
      mag_o = $unsigned(-data_i);
    end
  end
endmodule

// File: rtl/agc_defs.vh
// Shared AGC definitions: FSM state encodings and default tuning constants.
`ifndef AGC_DEFS_VH
`define AGC_DEFS_VH
localparam logic [1:0]  AGC_ST_ACCUM     = 2'd0;
localparam logic [1:0]  AGC_ST_EVAL      = 2'd1;
localparam logic [1:0]  AGC_ST_UPDATE    = 2'd2;
localparam int          AGC_WINDOW_LOG2  = 6;
localparam logic [11:0] AGC_TARGET       = 12'd512;
localparam logic [11:0] AGC_HYST         = 12'd32;
localparam logic [11:0] AGC_STEP         = 12'd16;
localparam logic [11:0] AGC_GAIN_INIT    = 12'd1024;
localparam logic [11:0] AGC_GAIN_MIN     = 12'd64;
localparam logic [11:0] AGC_GAIN_MAX     = 12'd4032;
`endif

// File: rtl/agc_gain_control.sv
// Windowed mean-magnitude AGC: accumulate a window, compare with a dead-band,
// then step the gain up or down within clamp limits. Registers use the falling edge.
module agc_gain_control
  import agc_gain_control_pkg::*;
#(
  parameter int          WINDOW_LOG2 = AGC_WINDOW_LOG2,
  parameter logic [11:0] TARGET      = AGC_TARGET,
  parameter logic [11:0] HYST        = AGC_HYST,
  parameter logic [11:0] STEP        = AGC_STEP,
  parameter logic [11:0] GAIN_INIT   = AGC_GAIN_INIT,
  parameter logic [11:0] GAIN_MIN    = AGC_GAIN_MIN,
  parameter logic [11:0] GAIN_MAX    = AGC_GAIN_MAX
) (
  input  logic        ip_clock,
  input  logic        ip_reset,
  input  logic [11:0] ip_data,
  input  logic        ip_valid,
  input  logic        ip_hold,
  output logic [11:0] op_gain,
  output logic        op_gain_valid,
  output logic [11:0] op_level,
  output logic        op_busy,
  output logic [1:0]  op_dbg_state
);
  localparam int ACC_W = 12 + WINDOW_LOG2;
  localparam logic [WINDOW_LOG2-1:0] CNT_LAST = '1;
  localparam logic signed [12:0] BAND_HI     = $signed({1'b0, TARGET}) + $signed({1'b0, HYST});
  localparam logic signed [12:0] BAND_LO_RAW = $signed({1'b0, TARGET}) - $signed({1'b0, HYST});
  localparam logic signed [12:0] BAND_LO     = (BAND_LO_RAW < 0) ? 13'sd0 : BAND_LO_RAW;

  agc_state_e              state_q, state_d;
  agc_dir_e                dir_q, dir_d;
  logic [ACC_W-1:0]        acc_q, acc_d;
  logic [WINDOW_LOG2-1:0]  cnt_q, cnt_d;
  logic [11:0]             level_q, level_d;
  logic [11:0]             gain_q, gain_d;

  logic [11:0]             mag;
  logic [ACC_W-1:0]        acc_sum;
  logic signed [12:0]      level_s;
  logic [12:0]             gain_up;
  logic signed [12:0]      gain_dn;
  logic [11:0]             gain_cand;
  logic                    apply;

  agc_abs u_abs (
    .data_i (ip_data),
    .mag_o  (mag)
  );

  assign acc_sum = acc_q + {{WINDOW_LOG2{1'b0}}, mag};
  assign level_s = $signed({1'b0, level_q});
  assign gain_up = {1'b0, gain_q} + {1'b0, STEP};
  assign gain_dn = $signed({1'b0, gain_q}) - $signed({1'b0, STEP});

  // The stepped gain is shown during UPDATE and committed on the edge leaving it,
  // so hold only has an effect in that one cycle.
  always_comb begin
    gain_cand = gain_q;
    case (dir_q)
      DIR_UP:   gain_cand = (gain_up > {1'b0, GAIN_MAX}) ? GAIN_MAX : gain_up[11:0];
      DIR_DOWN: gain_cand = (gain_dn < $signed({1'b0, GAIN_MIN})) ? GAIN_MIN : gain_dn[11:0];
      default:  gain_cand = gain_q;
    endcase
  end

  assign apply         = (state_q == ST_UPDATE) && !ip_hold;
  assign op_gain       = apply ? gain_cand : gain_q;
  assign op_gain_valid = apply;
  assign op_level      = level_q;
  assign op_busy       = (state_q == ST_EVAL) || (state_q == ST_UPDATE);
  assign op_dbg_state  = state_q;
  assign gain_d        = op_gain;

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    case (state_q)
      ST_ACCUM: begin
        if (ip_valid) begin
          acc_d = acc_sum;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            level_d = acc_sum[ACC_W-1:WINDOW_LOG2];
            state_d = ST_EVAL;
          end
        end
      end
      ST_EVAL: begin
        if (level_s > BAND_HI) begin
          dir_d = DIR_DOWN;
        end else if (level_s < BAND_LO) begin
          dir_d = DIR_UP;
        end else begin
          dir_d = DIR_NONE;
        end
        state_d = ST_UPDATE;
      end
      ST_UPDATE: begin
        acc_d   = '0;
        cnt_d   = '0;
        state_d = ST_ACCUM;
      end
      default: begin
        state_d = ST_ACCUM;
      end
    endcase
  end

  always_ff @(negedge ip_clock or negedge ip_reset) begin
    if (!ip_reset) begin
      state_q <= ST_ACCUM;
      dir_q   <= DIR_NONE;
      acc_q   <= '0;
      cnt_q   <= '0;
      level_q <= '0;
      gain_q  <= GAIN_INIT;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      gain_q  <= gain_d;
    end
  end
endmodule

// File: tb/tb_agc_gain_control.sv
// Bench for agc_gain_control with 4-sample windows; three instances differ only in GAIN_INIT.
module tb_agc_gain_control;
  localparam int TGT  = 512;
  localparam int HY   = 32;
  localparam int STP  = 16;
  localparam int GMIN = 64;
  localparam int GMAX = 4032;
  localparam int WIN  = 4;

  logic        clk = 1'b1;
  logic        rst_n;
  logic [11:0] data;
  logic        valid;
  logic        hold;
  logic [11:0] gain_o  [3];
  logic        gv_o    [3];
  logic [11:0] level_o [3];
  logic        busy_o  [3];
  logic [1:0]  dbg_o   [3];

  int total = 0;
  int bad   = 0;

  // clock / reset
  always #5 clk = ~clk;

  agc_gain_control #(.WINDOW_LOG2(2), .GAIN_INIT(12'd1024)) dut_a (
    .ip_clock(clk), .ip_reset(rst_n), .ip_data(data), .ip_valid(valid), .ip_hold(hold),
    .op_gain(gain_o[0]), .op_gain_valid(gv_o[0]), .op_level(level_o[0]), .op_busy(busy_o[0]),
    .op_dbg_state(dbg_o[0]));
  agc_gain_control #(.WINDOW_LOG2(2), .GAIN_INIT(12'd4032)) dut_hi (
    .ip_clock(clk), .ip_reset(rst_n), .ip_data(data), .ip_valid(valid), .ip_hold(hold),
    .op_gain(gain_o[1]), .op_gain_valid(gv_o[1]), .op_level(level_o[1]), .op_busy(busy_o[1]),
    .op_dbg_state(dbg_o[1]));
  agc_gain_control #(.WINDOW_LOG2(2), .GAIN_INIT(12'd64)) dut_lo (
    .ip_clock(clk), .ip_reset(rst_n), .ip_data(data), .ip_valid(valid), .ip_hold(hold),
    .op_gain(gain_o[2]), .op_gain_valid(gv_o[2]), .op_level(level_o[2]), .op_busy(busy_o[2]),
    .op_dbg_state(dbg_o[2]));

  // reference model: gains per instance, latched level, busy cycles remaining, open window
  int m_init [3] = '{1024, 4032, 64};
  int m_gain [3];
  int m_pend [3];
  int m_level;
  int m_busy;
  int m_win [$];
  logic [11:0] exp_q [$];

  int cyc       = 0;
  int mark      = 0;
  int pulse_cnt = 0;
  int pulse_at  = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sat_abs(input logic [11:0] d);
    int v;
    v = int'($signed(d));
    if (v == -2048) return 2047;
    return (v < 0) ? -v : v;
  endfunction

  function automatic int next_gain(input int lvl, input int g);
    int lo;
    lo = (TGT - HY < 0) ? 0 : TGT - HY;
    if (lvl > TGT + HY) return (g - STP < GMIN) ? GMIN : g - STP;
    if (lvl < lo) return (g + STP > GMAX) ? GMAX : g + STP;
    return g;
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < 3; i++) begin
      m_gain[i] = m_init[i];
      m_pend[i] = m_init[i];
    end
    m_level = 0;
    m_busy  = 0;
    m_win.delete();
    exp_q.delete();
  endfunction

  // driver: reset asserted at a rising edge, checked immediately, held over one active edge
  task automatic do_reset();
    @(posedge clk);
    rst_n = 1'b0;
    valid = 1'b0;
    hold  = 1'b0;
    #1;
    m_reset();
    for (int i = 0; i < 3; i++) begin
      chk("reset_gain",  gain_o[i],  m_init[i]);
      chk("reset_level", level_o[i], 0);
      chk("reset_gv",    gv_o[i],    0);
      chk("reset_busy",  busy_o[i],  0);
    end
    @(posedge clk);
    rst_n = 1'b1;
  endtask

  // driver + per-cycle scoreboard: drive at the rising edge, check, then advance the model
  task automatic cycle(input logic [11:0] d, input logic v, input logic h);
    int  exp_g;
    int  exp_st;
    logic exp_gv;
    int  sum;
    @(posedge clk);
    data  = d;
    valid = v;
    hold  = h;
    #1;
    cyc++;
    exp_gv = (m_busy == 1) && !h;
    exp_st = (m_busy == 2) ? 1 : (m_busy == 1) ? 2 : 0;
    for (int i = 0; i < 3; i++) begin
      exp_g = exp_gv ? m_pend[i] : m_gain[i];
      chk("gain",  gain_o[i],  exp_g);
      chk("gv",    gv_o[i],    exp_gv);
      chk("level", level_o[i], m_level);
      chk("busy",  busy_o[i],  m_busy != 0);
      chk("state", dbg_o[i],   exp_st);
    end
    if (exp_gv) exp_q.push_back(12'(m_pend[0]));
    if (gv_o[0] === 1'b1) begin
      pulse_cnt++;
      pulse_at = cyc - mark;
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", 1, 0);
      end else begin
        chk("pulse_gain", gain_o[0], exp_q.pop_front());
      end
    end
    if (exp_q.size() != 0) begin
      chk("missing_pulse", 0, 1);
      exp_q.delete();
    end
    if (m_busy == 1) begin
      if (!h) m_gain = m_pend;
      m_busy = 0;
    end else if (m_busy == 2) begin
      m_busy = 1;
    end else if (v) begin
      m_win.push_back(sat_abs(d));
      if (m_win.size() == WIN) begin
        sum = 0;
        foreach (m_win[k]) sum += m_win[k];
        m_level = sum / WIN;
        for (int i = 0; i < 3; i++) m_pend[i] = next_gain(m_level, m_gain[i]);
        m_busy = 2;
        m_win.delete();
      end
    end
  endtask

  task automatic run_window(input int s, input logic h);
    logic [11:0] d;
    d = s[11:0];
    pulse_cnt = 0;
    pulse_at  = -1;
    for (int k = 0; k < WIN; k++) cycle(d, 1'b1, h);
    mark = cyc;
    for (int k = 0; k < 3; k++) cycle(12'd0, 1'b0, h);
  endtask

  typedef struct {
    bit rst;
    int samp;
    bit hld;
    int lvl;
    int gain;
    int pulses;
  } vec_t;

  vec_t tbl [11];

  initial begin
    rst_n = 1'b0;
    data  = '0;
    valid = 1'b0;
    hold  = 1'b0;
    m_reset();

    tbl[0]  = '{1,  1000, 0, 1000, 1008, 1};
    tbl[1]  = '{1,  -100, 0,  100, 1040, 1};
    tbl[2]  = '{0,   512, 0,  512, 1040, 1};
    tbl[3]  = '{0,  1000, 1, 1000, 1040, 0};
    tbl[4]  = '{0,     0, 0,    0, 1056, 1};
    tbl[5]  = '{0,  2047, 0, 2047, 1040, 1};
    tbl[6]  = '{0,   544, 0,  544, 1040, 1};
    tbl[7]  = '{0,   545, 0,  545, 1024, 1};
    tbl[8]  = '{0,   480, 0,  480, 1024, 1};
    tbl[9]  = '{0,   479, 0,  479, 1040, 1};
    tbl[10] = '{0, -2048, 0, 2047, 1024, 1};

    do_reset();
    for (int t = 0; t < 11; t++) begin
      if (tbl[t].rst) do_reset();
      run_window(tbl[t].samp, tbl[t].hld);
      chk("tbl_level",  level_o[0], tbl[t].lvl);
      chk("tbl_gain",   gain_o[0],  tbl[t].gain);
      chk("tbl_pulses", pulse_cnt,  tbl[t].pulses);
      if (tbl[t].pulses != 0) chk("tbl_pulse_at", pulse_at, 2);
    end

    // clamping at both ends
    do_reset();
    run_window(0, 1'b0);
    chk("clamp_max_gain", gain_o[1], 4032);
    chk("clamp_lo_up",    gain_o[2], 80);
    do_reset();
    run_window(-2048, 1'b0);
    chk("clamp_min_level", level_o[2], 2047);
    chk("clamp_min_gain",  gain_o[2],  64);
    chk("clamp_hi_down",   gain_o[1],  4016);

    // reset in the middle of a window discards the partial sum
    do_reset();
    cycle(12'd1000, 1'b1, 1'b0);
    cycle(12'd1000, 1'b1, 1'b0);
    do_reset();
    run_window(0, 1'b0);
    chk("midrst_level", level_o[0], 0);
    chk("midrst_gain",  gain_o[0],  1040);

    // samples offered while busy are dropped
    for (int k = 0; k < WIN; k++) cycle(12'd300, 1'b1, 1'b0);
    cycle(12'd2047, 1'b1, 1'b0);
    chk("drop_busy_eval", busy_o[0], 1);
    cycle(12'd2047, 1'b1, 1'b0);
    chk("drop_busy_upd", busy_o[0], 1);
    chk("drop_level_300", level_o[0], 300);
    run_window(0, 1'b0);
    chk("drop_level", level_o[0], 0);
    chk("drop_gain",  gain_o[0],  1072);
    chk("drop_pulse_at", pulse_at, 2);

    // randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 249) == 0) begin
        do_reset();
      end else begin
        cycle(12'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
